// File: rtl/kd_sort_ctrl.sv
// kd-tree compare-exchange sequencer: odd-even transposition over tree levels.
// Optional round limit enabled by defining KD_SORT_TIMEOUT_EN.
module kd_sort_ctrl #(
  parameter  int DEPTH      = 3,
  parameter  int MAX_ROUNDS = 16,
  localparam int NUM_NODES  = 2**DEPTH - 1,
  localparam int NUM_CE     = 2**(DEPTH-1) - 1,
  localparam int NV_W       = $clog2(NUM_NODES + 1),
  localparam int RW         = $clog2(MAX_ROUNDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NV_W-1:0]   num_valid,
  input  logic [NUM_CE-1:0] ce_stable,
  output logic [NUM_CE-1:0] ce_en,
  output logic [NUM_CE-1:0] left_en,
  output logic [NUM_CE-1:0] right_en,
  output logic              sorting,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [RW-1:0]     rounds
);

  typedef enum logic [2:0] {
    IDLE,
    EVEN_FIRE,
    EVEN_WAIT,
    ODD_FIRE,
    ODD_WAIT,
    DONE_S
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_CE-1:0] left_q, left_d;
  logic [NUM_CE-1:0] right_q, right_d;
  logic [RW-1:0]     rounds_q, rounds_d;
  logic              timeout_q, timeout_d;
  logic              clean_q, clean_d;

  logic [NUM_CE-1:0] even_lvl;
  logic [NUM_CE-1:0] active;
  logic [NUM_CE-1:0] even_mask;
  logic [NUM_CE-1:0] odd_mask;
  logic              even_clean;
  logic              odd_clean;
  int                nv_int;
  int                nv_clamp;

  // node i sits on level floor(log2(i+1)) == $clog2(i+2)-1
  for (genvar g = 0; g < NUM_CE; g++) begin : g_lvl
    assign even_lvl[g] = ((($clog2(g + 2) - 1) % 2) == 0);
  end

  assign active     = left_q | right_q;
  assign even_mask  = even_lvl & active;
  assign odd_mask   = ~even_lvl & active;
  assign even_clean = &(ce_stable | ~even_mask);
  assign odd_clean  = &(ce_stable | ~odd_mask);

  always_comb begin
    nv_int   = 32'(num_valid);
    nv_clamp = (nv_int > NUM_NODES) ? NUM_NODES : nv_int;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      left_q    <= '0;
      right_q   <= '0;
      rounds_q  <= '0;
      timeout_q <= 1'b0;
      clean_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      left_q    <= left_d;
      right_q   <= right_d;
      rounds_q  <= rounds_d;
      timeout_q <= timeout_d;
      clean_q   <= clean_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    left_d    = left_q;
    right_d   = right_q;
    rounds_d  = rounds_q;
    timeout_d = timeout_q;
    clean_d   = clean_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < NUM_CE; i++) begin
            left_d[i]  = (2 * i + 1) < nv_clamp;
            right_d[i] = (2 * i + 2) < nv_clamp;
          end
          rounds_d  = '0;
          timeout_d = 1'b0;
          state_d   = (nv_clamp <= 1) ? DONE_S : EVEN_FIRE;
        end
      end
      EVEN_FIRE: state_d = EVEN_WAIT;
      EVEN_WAIT: begin
        clean_d = even_clean;
        state_d = ODD_FIRE;
      end
      ODD_FIRE: state_d = ODD_WAIT;
      ODD_WAIT: begin
        if (rounds_q != '1) rounds_d = rounds_q + 1'b1;
        if (clean_q && odd_clean) begin
          state_d = DONE_S;
`ifdef KD_SORT_TIMEOUT_EN
        end else if ((32'(rounds_q) + 1) == MAX_ROUNDS) begin
          state_d   = DONE_S;
          timeout_d = 1'b1;
`endif
        end else begin
          state_d = EVEN_FIRE;
        end
      end
      DONE_S:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ce_en   = '0;
    sorting = 1'b0;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE_S);
    unique case (state_q)
      EVEN_FIRE: begin
        ce_en   = even_mask;
        sorting = 1'b1;
      end
      ODD_FIRE: begin
        ce_en   = odd_mask;
        sorting = 1'b1;
      end
      EVEN_WAIT, ODD_WAIT: sorting = 1'b1;
      default: ;
    endcase
  end

  // timeout_q is only ever set when the round limit is compiled in
  assign timeout  = timeout_q;
  assign left_en  = left_q;
  assign right_en = right_q;
  assign rounds   = rounds_q;

endmodule

// File: tb/tb_kd_sort_ctrl.sv
// Scoreboard bench for kd_sort_ctrl (DEPTH=3, MAX_ROUNDS=16).
// Fire and done expectations are queued by stimulus, popped by the monitor.
module tb_kd_sort_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] num_valid;
  logic [2:0] ce_stable;
  logic [2:0] ce_en;
  logic [2:0] left_en;
  logic [2:0] right_en;
  logic       sorting;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [4:0] rounds;

  kd_sort_ctrl #(.DEPTH(3), .MAX_ROUNDS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_valid (num_valid),
    .ce_stable (ce_stable),
    .ce_en     (ce_en),
    .left_en   (left_en),
    .right_en  (right_en),
    .sorting   (sorting),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .rounds    (rounds)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] mask;
  } fire_t;

  typedef struct {
    int         cyc;
    logic [4:0] rounds;
    logic       to;
    logic [2:0] l;
    logic [2:0] r;
  } done_t;

  fire_t fq[$];
  done_t dq[$];
  fire_t f_m;
  done_t d_m;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_fire(input int c, input logic [2:0] m);
    fire_t f;
    f.cyc  = c;
    f.mask = m;
    fq.push_back(f);
  endtask

  task automatic push_done(input int c, input int r, input logic to,
                           input logic [2:0] l, input logic [2:0] rr);
    done_t d;
    d.cyc    = c;
    d.rounds = 5'(r);
    d.to     = to;
    d.l      = l;
    d.r      = rr;
    dq.push_back(d);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [2:0] prev_ce = 3'b000;

  always @(negedge clk) begin
    if (ce_en !== 3'b000 && !$isunknown(ce_en)) begin
      chk("ce_en_back_to_back", 32'(prev_ce & ce_en), 0);
      if (fq.size() == 0) begin
        chk("unexpected_fire", 32'(ce_en), 0);
      end else begin
        f_m = fq.pop_front();
        chk("fire_cycle", cyc, f_m.cyc);
        chk("fire_mask", 32'(ce_en), 32'(f_m.mask));
      end
    end
    prev_ce = ce_en;
    if (done === 1'b1) begin
      if (dq.size() == 0) begin
        chk("unexpected_done", 32'(done), 0);
      end else begin
        d_m = dq.pop_front();
        chk("done_cycle", cyc, d_m.cyc);
        chk("done_rounds", 32'(rounds), 32'(d_m.rounds));
        chk("done_timeout", 32'(timeout), 32'(d_m.to));
        chk("done_left_en", 32'(left_en), 32'(d_m.l));
        chk("done_right_en", 32'(right_en), 32'(d_m.r));
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ce_en"}, 32'(ce_en), 0);
    chk({tag, "_left_en"}, 32'(left_en), 0);
    chk({tag, "_right_en"}, 32'(right_en), 0);
    chk({tag, "_sorting"}, 32'(sorting), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_rounds"}, 32'(rounds), 0);
  endtask

  int t;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    num_valid = 3'd0;
    ce_stable = 3'b000;
    tick(3);
    chk_zero("reset");
    rst = 1'b0;

    // all stable, full tree: one round
    ce_stable = 3'b111;
    tick(1);
    t = cyc;
    push_fire(t + 1, 3'b001);
    push_fire(t + 3, 3'b110);
    push_done(t + 5, 1, 1'b0, 3'b111, 3'b111);
    start = 1'b1;
    num_valid = 3'd7;
    tick(1);
    start = 1'b0;
    chk("s1_busy", 32'(busy), 1);
    chk("s1_sorting", 32'(sorting), 1);
    tick(6);
    chk("s1_pending", dq.size() + fq.size(), 0);

    // odd CE 1 unstable in the first odd wait: two rounds
    tick(1);
    t = cyc;
    push_fire(t + 1, 3'b001);
    push_fire(t + 3, 3'b110);
    push_fire(t + 5, 3'b001);
    push_fire(t + 7, 3'b110);
    push_done(t + 9, 2, 1'b0, 3'b111, 3'b111);
    start = 1'b1;
    num_valid = 3'd7;
    tick(1);
    start = 1'b0;
    tick(3);
    ce_stable = 3'b101;
    tick(1);
    ce_stable = 3'b111;
    tick(6);
    chk("s2_pending", dq.size() + fq.size(), 0);

    // partial tree of 4 nodes
    tick(1);
    t = cyc;
    push_fire(t + 1, 3'b001);
    push_fire(t + 3, 3'b010);
    push_done(t + 5, 1, 1'b0, 3'b011, 3'b001);
    start = 1'b1;
    num_valid = 3'd4;
    tick(1);
    start = 1'b0;
    tick(6);
    chk("s3_pending", dq.size() + fq.size(), 0);

`ifdef KD_SORT_TIMEOUT_EN
    // never converges: round limit
    ce_stable = 3'b000;
    tick(1);
    t = cyc;
    for (int k = 0; k < 16; k++) begin
      push_fire(t + 1 + 4 * k, 3'b001);
      push_fire(t + 3 + 4 * k, 3'b110);
    end
    push_done(t + 65, 16, 1'b1, 3'b111, 3'b111);
    start = 1'b1;
    num_valid = 3'd7;
    tick(1);
    start = 1'b0;
    tick(66);
    chk("s4_pending", dq.size() + fq.size(), 0);
`endif

    // reset mid-sort aborts with no done
    ce_stable = 3'b000;
    tick(1);
    t = cyc;
    push_fire(t + 1, 3'b001);
    push_fire(t + 3, 3'b110);
    push_fire(t + 5, 3'b001);
    start = 1'b1;
    num_valid = 3'd7;
    tick(1);
    start = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(1);
    chk_zero("abort");
    rst = 1'b0;
    tick(20);
    chk("s5_pending", dq.size() + fq.size(), 0);

    // single node: immediate done
    ce_stable = 3'b111;
    tick(1);
    t = cyc;
    push_done(t + 1, 0, 1'b0, 3'b000, 3'b000);
    start = 1'b1;
    num_valid = 3'd1;
    tick(1);
    start = 1'b0;
    tick(4);
    chk("s5b_pending", dq.size() + fq.size(), 0);

    // second start mid-sort is ignored
    tick(1);
    t = cyc;
    push_fire(t + 1, 3'b001);
    push_fire(t + 3, 3'b110);
    push_done(t + 5, 1, 1'b0, 3'b111, 3'b111);
    start = 1'b1;
    num_valid = 3'd7;
    tick(1);
    start = 1'b0;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(10);
    chk("s6_pending", dq.size() + fq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/kd_sort_ctrl.md
# kd_sort_ctrl

Sequencing controller that sits directly upstream of the array of cluster compare-exchange (CE) nodes in the kd-tree. It drives each CE's `en`, `sorting`, `left_en` and `right_en` inputs. It alternates even-level and odd-level CE phases, an odd-even transposition over tree levels, and collects the CEs' `stable` flags. It reports completion when one full even+odd round produces no swap, or when the round limit is hit.

## Interface
Parameters:
- `DEPTH`, 3: tree levels. Derived `NUM_NODES = 2**DEPTH - 1`, `NUM_CE = 2**(DEPTH-1) - 1`, one CE per internal node, heap-indexed. Node i has children 2i+1 and 2i+2.
- `MAX_ROUNDS`, 16: round limit. Used only with `KD_SORT_TIMEOUT_EN`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a sort. Sampled only in IDLE.
- `num_valid` in $clog2(NUM_NODES+1): number of occupied nodes. Nodes 0..num_valid-1 are occupied. Sampled with `start`.
- `ce_stable` in NUM_CE: bit i is CE i's `stable` output.
- `ce_en` out NUM_CE: bit i drives CE i's `en`.
- `left_en` out NUM_CE: bit i is high iff (2i+1) < num_valid.
- `right_en` out NUM_CE: bit i is high iff (2i+2) < num_valid.
- `sorting` out 1: drives all CEs' `sorting`. High in every FIRE/WAIT state.
- `busy` out 1: high whenever the controller is not in IDLE.
- `done` out 1: one-cycle completion pulse.
- `timeout` out 1: valid with `done`. Indicates the round limit was reached without convergence.
- `rounds` out $clog2(MAX_ROUNDS+1): number of rounds run. Held until the next accepted `start`.

## Operation
- States: IDLE, EVEN_FIRE, EVEN_WAIT, ODD_FIRE, ODD_WAIT, DONE.
- Phase masks:
  - even_mask[i] is high when node i is on an even level, i.e. floor(log2(i+1)) is even.
  - odd_mask is the complement of even_mask.
  - Both are ANDed with active[i] = left_en[i] | right_en[i].
- IDLE, on `start`:
  - Register clamp(num_valid, NUM_NODES).
  - Compute `left_en`/`right_en` and clear `rounds`, `timeout`.
  - Go to EVEN_FIRE. Exception: if clamped num_valid ≤ 1, no CE is active; go to DONE with `rounds`=0.
- EVEN_FIRE: `ce_en` = even-phase mask for one cycle, then EVEN_WAIT.
- EVEN_WAIT:
  - `ce_en`=0.
  - Set round_clean = &(ce_stable | ~even-phase mask).
  - Go to ODD_FIRE.
- ODD_FIRE: `ce_en` = odd-phase mask for one cycle, then ODD_WAIT.
- ODD_WAIT:
  - `ce_en`=0. `rounds` increments, saturating.
  - If round_clean & &(ce_stable | ~odd-phase mask), go to DONE.
  - Otherwise, if the timeout feature is on and `rounds`+1 == MAX_ROUNDS, go to DONE with `timeout`=1.
  - Otherwise go to EVEN_FIRE.
  - A phase with an empty mask counts as clean.
- DONE: `done`=1 for one cycle, then IDLE. `left_en`/`right_en` hold their values until the next `start`.
- `start` outside IDLE is ignored.

## Timing
- Reset values: all outputs are 0 and the state is IDLE. `rst` mid-sort aborts the sort: by the next cycle all outputs are 0 and no `done` is issued.
- One round takes 4 cycles. The WAIT cycle covers the CE's one-cycle registered result; `ce_stable` is sampled at the end of the WAIT cycle.
- `start` accepted at cycle t:
  - Even fire at t+1, odd fire at t+3.
  - `done` at t+4n+1, where n is the final `rounds`.
  - In the num_valid ≤ 1 case, `done` is at t+1.
- `ce_en` bits are never high in two consecutive cycles.

## Configuration
- `KD_SORT_TIMEOUT_EN` defined: the round limit is enforced and `timeout` is functional.
- `KD_SORT_TIMEOUT_EN` not defined:
  - `timeout` is tied 0.
  - The controller runs until convergence.
  - `rounds` saturates at its maximum value and does not wrap.

## Test plan
All scenarios use DEPTH=3 (NUM_CE=3), MAX_ROUNDS=16 and the macro defined.
- num_valid=7, ce_stable=3'b111 constant. Expect:
  - `left_en`=`right_en`=3'b111.
  - `ce_en`=3'b001 at t+1 and 3'b110 at t+3.
  - `done`=1 at t+5 with `rounds`=1, `timeout`=0.
- num_valid=7, ce_stable[1]=0 during the first ODD_WAIT only. Expect:
  - A second round runs.
  - `done` at t+9 with `rounds`=2.
- num_valid=4, ce_stable=3'b111. Expect:
  - `left_en`=3'b011, `right_en`=3'b001.
  - Odd fire `ce_en`=3'b010.
  - `done` at t+5.
- ce_stable=3'b000 forever, num_valid=7. Expect `done` at t+65 with `timeout`=1, `rounds`=16.
- `rst` asserted at t+6 of the previous scenario. Expect all outputs 0 at t+7 and no `done` afterwards. Then `start` with num_valid=1: expect `done` at t+1 with `rounds`=0.
- `start` pulsed again at t+2 during a sort. Expect it to be ignored: one `done` only, with unchanged timing.
